// File: rtl/core_pkg.sv
// Shared types and constants for the RV32 pipeline: control bundle, datapath width,
// register-zero index and the decode/execute slot state encoding.
package core_pkg;

    localparam int unsigned XLEN     = 32;
    localparam logic [4:0]  REG_ZERO = 5'd0;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       alu_src_imm;
        logic       uses_rs1;
        logic       uses_rs2;
        logic       mem_read;
        logic       mem_write;
        logic       write_back;
        logic       branch;
        logic       jump;
    } ctrl_t;

    typedef enum logic {
        SlotEmpty = 1'b0,
        SlotFull  = 1'b1
    } slot_e;

endpackage

// File: rtl/operand_forward.sv
// Combinational operand bypass for one source register.
// Priority: x0, then EX/MEM (non-load only), then MEM/WB, then the captured value.
module operand_forward
    import core_pkg::*;
(
    input  logic [4:0]      i_rs,
    input  logic [XLEN-1:0] i_captured,
    input  logic [4:0]      i_mem_rd,
    input  logic            i_mem_write_back,
    input  logic            i_mem_is_load,
    input  logic [XLEN-1:0] i_mem_result,
    input  logic [4:0]      i_wb_rd,
    input  logic            i_wb_write_back,
    input  logic [XLEN-1:0] i_wb_data,
    output logic [XLEN-1:0] o_operand
);

    logic w_mem_hit;
    logic w_wb_hit;

    // A load's data is not ready in EX/MEM; it must come through MEM/WB instead.
    assign w_mem_hit = i_mem_write_back && (i_mem_rd != REG_ZERO) && (i_mem_rd == i_rs)
                       && !i_mem_is_load;
    assign w_wb_hit  = i_wb_write_back && (i_wb_rd != REG_ZERO) && (i_wb_rd == i_rs);

    always_comb begin
        o_operand = i_captured;
        if (i_rs == REG_ZERO) begin
            o_operand = '0;
        end else if (w_mem_hit) begin
            o_operand = i_mem_result;
        end else if (w_wb_hit) begin
            o_operand = i_wb_data;
        end
    end

endmodule

// File: rtl/decode_execute_stage.sv
// ID/EX pipeline register: captures the decoded instruction, forwards operands,
// inserts load-use bubbles, holds under execute back-pressure and drops on flush.
module decode_execute_stage
    import core_pkg::*;
(
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            id_valid_i,
    input  logic [XLEN-1:0] id_pc_i,
    input  logic [4:0]      id_rs1_i,
    input  logic [4:0]      id_rs2_i,
    input  logic [4:0]      id_rd_i,
    input  logic [XLEN-1:0] id_rs1_data_i,
    input  logic [XLEN-1:0] id_rs2_data_i,
    input  logic [XLEN-1:0] id_imm_i,
    input  ctrl_t           id_ctrl_i,
    input  logic            flush_i,
    input  logic            ex_ready_i,
    input  logic [4:0]      mem_rd_i,
    input  logic            mem_write_back_i,
    input  logic            mem_is_load_i,
    input  logic [XLEN-1:0] mem_result_i,
    input  logic [4:0]      wb_rd_i,
    input  logic            wb_write_back_i,
    input  logic [XLEN-1:0] wb_data_i,
    output logic            stall_o,
    output logic            ex_valid_o,
    output logic [XLEN-1:0] ex_pc_o,
    output logic [XLEN-1:0] ex_imm_o,
    output logic [4:0]      ex_rs1_o,
    output logic [4:0]      ex_rs2_o,
    output logic [4:0]      ex_rd_o,
    output ctrl_t           ex_ctrl_o,
    output logic [XLEN-1:0] ex_op_a_o,
    output logic [XLEN-1:0] ex_op_b_o
);

    slot_e           r_state;
    slot_e           w_state_next;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_imm;
    logic [XLEN-1:0] r_rs1_data;
    logic [XLEN-1:0] r_rs2_data;
    logic [4:0]      r_rs1;
    logic [4:0]      r_rs2;
    logic [4:0]      r_rd;
    ctrl_t           r_ctrl;

    logic            w_full;
    logic            w_hold;
    logic            w_load_use;
    logic            w_capture;
    logic            w_refresh;
    logic [XLEN-1:0] w_op_a;
    logic [XLEN-1:0] w_op_b;

    assign w_full = (r_state == SlotFull);
    assign w_hold = w_full && !ex_ready_i;

    assign w_load_use = w_full && r_ctrl.mem_read && (r_rd != REG_ZERO) && id_valid_i
                        && ((id_ctrl_i.uses_rs1 && (r_rd == id_rs1_i))
                         || (id_ctrl_i.uses_rs2 && (r_rd == id_rs2_i)));

    assign stall_o = reset_i && !flush_i && (w_load_use || w_hold);

    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_refresh    = 1'b0;
        if (flush_i) begin
            w_state_next = SlotEmpty;
        end else if (w_hold) begin
            w_refresh = 1'b1;
        end else if (w_load_use) begin
            w_state_next = SlotEmpty;
        end else begin
            w_capture    = 1'b1;
            w_state_next = id_valid_i ? SlotFull : SlotEmpty;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            r_state <= SlotEmpty;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            r_pc       <= '0;
            r_imm      <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
            r_ctrl     <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
        end else if (w_capture) begin
            r_pc       <= id_pc_i;
            r_imm      <= id_imm_i;
            r_rs1      <= id_rs1_i;
            r_rs2      <= id_rs2_i;
            r_rd       <= id_rd_i;
            r_ctrl     <= id_ctrl_i;
            r_rs1_data <= id_rs1_data_i;
            r_rs2_data <= id_rs2_data_i;
        end else if (w_refresh) begin
            // Keep the held operands current so a write retiring during the hold is kept.
            r_rs1_data <= w_op_a;
            r_rs2_data <= w_op_b;
        end
    end

    operand_forward u_fwd_rs1 (
        .i_rs             (r_rs1),
        .i_captured       (r_rs1_data),
        .i_mem_rd         (mem_rd_i),
        .i_mem_write_back (mem_write_back_i),
        .i_mem_is_load    (mem_is_load_i),
        .i_mem_result     (mem_result_i),
        .i_wb_rd          (wb_rd_i),
        .i_wb_write_back  (wb_write_back_i),
        .i_wb_data        (wb_data_i),
        .o_operand        (w_op_a)
    );

    operand_forward u_fwd_rs2 (
        .i_rs             (r_rs2),
        .i_captured       (r_rs2_data),
        .i_mem_rd         (mem_rd_i),
        .i_mem_write_back (mem_write_back_i),
        .i_mem_is_load    (mem_is_load_i),
        .i_mem_result     (mem_result_i),
        .i_wb_rd          (wb_rd_i),
        .i_wb_write_back  (wb_write_back_i),
        .i_wb_data        (wb_data_i),
        .o_operand        (w_op_b)
    );

    assign ex_valid_o = w_full;
    assign ex_pc_o    = r_pc;
    assign ex_imm_o   = r_imm;
    assign ex_rs1_o   = r_rs1;
    assign ex_rs2_o   = r_rs2;
    assign ex_rd_o    = r_rd;
    assign ex_ctrl_o  = r_ctrl;
    assign ex_op_a_o  = w_op_a;
    assign ex_op_b_o  = w_op_b;

`ifndef SYNTHESIS
    logic w_load_conflict;

    // The load-use bubble must keep a pending load from ever meeting its consumer here.
    assign w_load_conflict = w_full && mem_write_back_i && mem_is_load_i
                             && (mem_rd_i != REG_ZERO)
                             && ((r_ctrl.uses_rs1 && (mem_rd_i == r_rs1))
                              || (r_ctrl.uses_rs2 && (mem_rd_i == r_rs2)));

    a_no_load_conflict : assert property (@(posedge clk_i) disable iff (!reset_i)
                                          !w_load_conflict);
`endif

endmodule

// File: tb/tb_decode_execute_stage.sv
// Randomized scoreboard bench for decode_execute_stage with a few directed scenarios.
module tb_decode_execute_stage;
    import core_pkg::*;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b0;
    logic        id_valid_i = 1'b0;
    logic [31:0] id_pc_i = '0, id_rs1_data_i = '0, id_rs2_data_i = '0, id_imm_i = '0;
    logic [4:0]  id_rs1_i = '0, id_rs2_i = '0, id_rd_i = '0;
    ctrl_t       id_ctrl_i = '0;
    logic        flush_i = 1'b0, ex_ready_i = 1'b1;
    logic [4:0]  mem_rd_i = '0, wb_rd_i = '0;
    logic        mem_write_back_i = 1'b0, mem_is_load_i = 1'b0, wb_write_back_i = 1'b0;
    logic [31:0] mem_result_i = '0, wb_data_i = '0;
    logic        stall_o, ex_valid_o;
    logic [31:0] ex_pc_o, ex_imm_o, ex_op_a_o, ex_op_b_o;
    logic [4:0]  ex_rs1_o, ex_rs2_o, ex_rd_o;
    ctrl_t       ex_ctrl_o;

    always #5 clk_i = ~clk_i;

    decode_execute_stage dut (
        .clk_i(clk_i), .reset_i(reset_i), .id_valid_i(id_valid_i), .id_pc_i(id_pc_i),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
        .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i), .id_imm_i(id_imm_i),
        .id_ctrl_i(id_ctrl_i), .flush_i(flush_i), .ex_ready_i(ex_ready_i),
        .mem_rd_i(mem_rd_i), .mem_write_back_i(mem_write_back_i),
        .mem_is_load_i(mem_is_load_i), .mem_result_i(mem_result_i), .wb_rd_i(wb_rd_i),
        .wb_write_back_i(wb_write_back_i), .wb_data_i(wb_data_i), .stall_o(stall_o),
        .ex_valid_o(ex_valid_o), .ex_pc_o(ex_pc_o), .ex_imm_o(ex_imm_o),
        .ex_rs1_o(ex_rs1_o), .ex_rs2_o(ex_rs2_o), .ex_rd_o(ex_rd_o), .ex_ctrl_o(ex_ctrl_o),
        .ex_op_a_o(ex_op_a_o), .ex_op_b_o(ex_op_b_o)
    );

    typedef struct {
        logic        rst_n, id_valid, flush, ready, mem_wb, mem_load, wb_wb;
        logic [31:0] pc, rs1_data, rs2_data, imm, mem_result, wb_data;
        logic [4:0]  rs1, rs2, rd, mem_rd, wb_rd;
        ctrl_t       ctrl;
    } stim_t;

    typedef struct { logic stall; logic valid; logic zeroed; } cyc_exp_t;
    typedef struct {
        logic [31:0] pc, imm, a, b;
        logic [4:0]  rs1, rs2, rd;
        ctrl_t       ctrl;
    } iss_exp_t;

    cyc_exp_t cyc_q[$];
    iss_exp_t iss_q[$];
    int checks = 0;
    int failures = 0;

    // Reference slot: what the execute stage should be holding right now.
    logic        m_valid = 1'b0, m_zeroed = 1'b1;
    logic [31:0] m_pc = '0, m_imm = '0, m_a = '0, m_b = '0;
    logic [4:0]  m_rs1 = '0, m_rs2 = '0, m_rd = '0;
    ctrl_t       m_ctrl = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Value the execute stage should see for register idx given this cycle's retirements.
    function automatic logic [31:0] value_of(input logic [4:0] idx, input logic [31:0] held,
                                             input stim_t s);
        if (idx == 5'd0) return 32'd0;
        if (s.mem_wb && s.mem_rd == idx && !s.mem_load) return s.mem_result;
        if (s.wb_wb && s.wb_rd == idx) return s.wb_data;
        return held;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '{rst_n: 1'b1, ready: 1'b1, default: '0};
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        logic [11:0] cbits;
        cbits      = 12'($urandom);
        s          = idle();
        s.rst_n    = ($urandom_range(0, 63) != 0);
        s.id_valid = ($urandom_range(0, 3) != 0);
        s.flush    = ($urandom_range(0, 9) == 0);
        s.ready    = ($urandom_range(0, 3) != 0);
        s.pc       = $urandom;
        s.imm      = $urandom;
        s.rs1_data = $urandom;
        s.rs2_data = $urandom;
        s.rs1      = 5'($urandom_range(0, 7));
        s.rs2      = 5'($urandom_range(0, 7));
        s.rd       = 5'($urandom_range(0, 7));
        s.ctrl     = ctrl_t'(cbits);
        s.mem_rd   = 5'($urandom_range(0, 7));
        s.mem_wb   = $urandom_range(0, 1) == 1;
        s.mem_load = $urandom_range(0, 1) == 1;
        s.mem_result = $urandom;
        s.wb_rd    = 5'($urandom_range(0, 7));
        s.wb_wb    = $urandom_range(0, 1) == 1;
        s.wb_data  = $urandom;
        return s;
    endfunction

    task automatic step(input stim_t s_in);
        stim_t       s;
        logic        lu, stall;
        logic [31:0] a, b;
        s = s_in;
        @(posedge clk_i);
        #1;
        // A load cannot legally sit in EX/MEM while its consumer is in the slot.
        if (m_valid && s.mem_wb && s.mem_load && s.mem_rd != 5'd0 &&
            ((m_ctrl.uses_rs1 && s.mem_rd == m_rs1) || (m_ctrl.uses_rs2 && s.mem_rd == m_rs2)))
            s.mem_load = 1'b0;
        reset_i = s.rst_n;  id_valid_i = s.id_valid;  id_pc_i = s.pc;  id_imm_i = s.imm;
        id_rs1_i = s.rs1;  id_rs2_i = s.rs2;  id_rd_i = s.rd;  id_ctrl_i = s.ctrl;
        id_rs1_data_i = s.rs1_data;  id_rs2_data_i = s.rs2_data;
        flush_i = s.flush;  ex_ready_i = s.ready;
        mem_rd_i = s.mem_rd;  mem_write_back_i = s.mem_wb;  mem_is_load_i = s.mem_load;
        mem_result_i = s.mem_result;
        wb_rd_i = s.wb_rd;  wb_write_back_i = s.wb_wb;  wb_data_i = s.wb_data;

        lu = m_valid && m_ctrl.mem_read && m_rd != 5'd0 && s.id_valid &&
             ((s.ctrl.uses_rs1 && m_rd == s.rs1) || (s.ctrl.uses_rs2 && m_rd == s.rs2));
        stall = s.rst_n && !s.flush && (lu || (m_valid && !s.ready));
        a = value_of(m_rs1, m_a, s);
        b = value_of(m_rs2, m_b, s);
        cyc_q.push_back('{stall: stall, valid: m_valid, zeroed: m_zeroed});
        if (m_valid && s.ready)
            iss_q.push_back('{pc: m_pc, imm: m_imm, a: a, b: b, rs1: m_rs1, rs2: m_rs2,
                              rd: m_rd, ctrl: m_ctrl});

        m_zeroed = 1'b0;
        if (!s.rst_n) begin
            m_valid = 1'b0;  m_zeroed = 1'b1;
            m_pc = '0;  m_imm = '0;  m_a = '0;  m_b = '0;
            m_rs1 = '0;  m_rs2 = '0;  m_rd = '0;  m_ctrl = '0;
        end else if (s.flush) begin
            m_valid = 1'b0;
        end else if (m_valid && !s.ready) begin
            m_a = a;
            m_b = b;
        end else if (lu) begin
            m_valid = 1'b0;
        end else begin
            m_valid = s.id_valid;  m_pc = s.pc;  m_imm = s.imm;
            m_rs1 = s.rs1;  m_rs2 = s.rs2;  m_rd = s.rd;  m_ctrl = s.ctrl;
            m_a = s.rs1_data;  m_b = s.rs2_data;
        end
    endtask

    // Monitor: per-cycle status, and each instruction execute accepts.
    initial begin
        cyc_exp_t c;
        iss_exp_t e;
        forever begin
            @(negedge clk_i);
            if (cyc_q.size() > 0) begin
                c = cyc_q.pop_front();
                chk("stall", {31'd0, stall_o}, {31'd0, c.stall});
                chk("ex_valid", {31'd0, ex_valid_o}, {31'd0, c.valid});
                if (c.zeroed) begin
                    chk("reset_pc", ex_pc_o, 32'd0);
                    chk("reset_imm", ex_imm_o, 32'd0);
                    chk("reset_op_a", ex_op_a_o, 32'd0);
                    chk("reset_op_b", ex_op_b_o, 32'd0);
                    chk("reset_idx_ctrl", {5'd0, ex_rs1_o, ex_rs2_o, ex_rd_o, ex_ctrl_o}, 32'd0);
                end
            end
            if (ex_valid_o === 1'b1 && ex_ready_i === 1'b1) begin
                if (iss_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL issue_unexpected actual=pc_%0h required=no_issue", ex_pc_o);
                end else begin
                    e = iss_q.pop_front();
                    chk("issue_pc", ex_pc_o, e.pc);
                    chk("issue_imm", ex_imm_o, e.imm);
                    chk("issue_idx", {17'd0, ex_rs1_o, ex_rs2_o, ex_rd_o},
                        {17'd0, e.rs1, e.rs2, e.rd});
                    chk("issue_ctrl", {20'd0, ex_ctrl_o}, {20'd0, e.ctrl});
                    chk("issue_op_a", ex_op_a_o, e.a);
                    chk("issue_op_b", ex_op_b_o, e.b);
                end
            end
        end
    end

    initial begin
        stim_t s;
        s = idle();
        s.rst_n = 1'b0;
        step(s);
        step(idle());

        // EX/MEM beats MEM/WB for a stale captured rs1.
        s = idle();  s.id_valid = 1'b1;  s.rs1 = 5'd5;  s.ctrl.uses_rs1 = 1'b1;  s.pc = 32'h100;
        step(s);
        s = idle();  s.mem_wb = 1'b1;  s.mem_rd = 5'd5;  s.mem_result = 32'h10;
        s.wb_wb = 1'b1;  s.wb_rd = 5'd5;  s.wb_data = 32'h20;
        step(s);

        // x0 never forwards.
        s = idle();  s.id_valid = 1'b1;  s.rs1 = 5'd0;  s.rs1_data = 32'h1234;
        step(s);
        s = idle();  s.mem_wb = 1'b1;  s.mem_rd = 5'd0;  s.mem_result = 32'hDEAD;
        step(s);

        // Load to x7 followed by a consumer of x7: one bubble, then MEM/WB supplies the data.
        s = idle();  s.id_valid = 1'b1;  s.rd = 5'd7;  s.ctrl.mem_read = 1'b1;
        s.ctrl.write_back = 1'b1;
        step(s);
        s = idle();  s.id_valid = 1'b1;  s.rs2 = 5'd7;  s.ctrl.uses_rs2 = 1'b1;  s.pc = 32'h200;
        step(s);
        s.mem_wb = 1'b1;  s.mem_rd = 5'd7;  s.mem_load = 1'b1;
        step(s);
        s = idle();  s.wb_wb = 1'b1;  s.wb_rd = 5'd7;  s.wb_data = 32'hCAFE;
        step(s);

        // Three-cycle hold; WB retires x3 in the second cycle.
        s = idle();  s.id_valid = 1'b1;  s.rs1 = 5'd3;  s.ctrl.uses_rs1 = 1'b1;
        step(s);
        s = idle();  s.ready = 1'b0;
        step(s);
        s.wb_wb = 1'b1;  s.wb_rd = 5'd3;  s.wb_data = 32'h55;
        step(s);
        s = idle();  s.ready = 1'b0;
        step(s);
        step(idle());

        // Flush together with load-use and back-pressure.
        s = idle();  s.id_valid = 1'b1;  s.rd = 5'd7;  s.ctrl.mem_read = 1'b1;
        step(s);
        s = idle();  s.id_valid = 1'b1;  s.rs2 = 5'd7;  s.ctrl.uses_rs2 = 1'b1;
        s.ready = 1'b0;  s.flush = 1'b1;
        step(s);
        step(idle());

        // Reset in the middle of a hold.
        s = idle();  s.id_valid = 1'b1;  s.pc = 32'h300;  s.rs1 = 5'd2;  s.rs1_data = 32'h9;
        step(s);
        s = idle();  s.ready = 1'b0;
        step(s);
        s.rst_n = 1'b0;
        step(s);
        step(idle());

        for (int i = 0; i < 2000; i++) step(rand_stim());
        step(idle());
        @(negedge clk_i);
        #1;
        checks++;
        if (iss_q.size() != 0 || cyc_q.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d/%0d required=0/0", iss_q.size(), cyc_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decode_execute_stage.md
# decode_execute_stage

Pipeline boundary between decode and execute in the pipelined RV32 core. Registers the decoded instruction and the two operand values read from the register file. Applies EX/MEM and MEM/WB operand forwarding and detects load-use hazards. Inserts bubbles, holds under execute back-pressure, and discards wrong-path instructions on flush.

## Interface
- XLEN, 32, datapath width
- clk_i  in  1  core clock
- reset_i  in  1  synchronous, active-low reset
- id_valid_i  in  1  decode slot holds a real instruction
- id_pc_i  in  XLEN  instruction PC
- id_rs1_i, id_rs2_i, id_rd_i  in  5  register indices
- id_rs1_data_i, id_rs2_data_i  in  XLEN  register file read data; already bypasses same-cycle WB writes
- id_imm_i  in  XLEN  decoded immediate
- id_ctrl_i  in  ctrl_t  decoded control bundle
- flush_i  in  1  branch/jump redirect resolved in EX
- ex_ready_i  in  1  execute accepts the current instruction this cycle
- mem_rd_i  in  5  EX/MEM destination
- mem_write_back_i  in  1  EX/MEM writes a register
- mem_is_load_i  in  1  EX/MEM holds a load
- mem_result_i  in  XLEN  EX/MEM ALU result
- wb_rd_i  in  5  MEM/WB destination
- wb_write_back_i  in  1  MEM/WB writes a register
- wb_data_i  in  XLEN  MEM/WB write-back value
- stall_o  out  1  hold fetch and decode this cycle
- ex_valid_o  out  1  execute slot valid
- ex_pc_o, ex_imm_o  out  XLEN  registered PC and immediate
- ex_rs1_o, ex_rs2_o, ex_rd_o  out  5  registered register indices
- ex_ctrl_o  out  ctrl_t  registered control bundle
- ex_op_a_o, ex_op_b_o  out  XLEN  forwarded rs1 and rs2 operands

## Operation
- **Slot states:** EMPTY (ex_valid_o=0) and FULL (ex_valid_o=1). Transitions at each clock edge:
  - flush_i=1 → EMPTY.
  - FULL with ex_ready_i=0 → HOLD. Stays FULL with all fields unchanged, except operand refresh (below).
  - load_use=1 → EMPTY. This is the bubble; the ID instruction is not captured.
  - Otherwise the slot loads the ID fields and ex_valid_o ← id_valid_i.
- **load_use:** asserted when all of the following hold:
  - ex_valid_o=1 and ex_ctrl_o.mem_read=1 and ex_rd_o≠0;
  - id_valid_i=1;
  - ex_rd_o equals id_rs1_i (when ctrl uses rs1) or id_rs2_i (when ctrl uses rs2).
- **stall_o** = !flush_i & (load_use | (ex_valid_o & !ex_ready_i)). Flush always overrides stall.
- **Forwarding** is evaluated per operand in the same cycle, in priority order:
  1. EX/MEM match: mem_write_back_i & mem_rd_i≠0 & mem_rd_i==ex_rsN_o & !mem_is_load_i → mem_result_i.
  2. MEM/WB match: wb_write_back_i & wb_rd_i≠0 & wb_rd_i==ex_rsN_o → wb_data_i.
  3. Otherwise → the captured register value.
- A source index of 0 always yields operand 0.
- A load in EX/MEM that matches a FULL slot's source is illegal, because the bubble prevents it. This is checked by assertion.
- **Operand refresh:** during HOLD, the captured rs1/rs2 values are overwritten each cycle with the current forwarded values. A write that retires while the slot is held is therefore not lost.

## Timing
- Reset (reset_i=0 at a clock edge) clears the slot to EMPTY and sets all registered outputs to 0. During reset, stall_o is 0. Reset mid-stall or mid-hold discards the slot.
- Latency is 1 cycle from ID capture to the ex_* outputs.
- stall_o, ex_op_a_o and ex_op_b_o are combinational from state and inputs. All other outputs come straight from registers.
- A load-use hazard costs exactly one bubble cycle. On the next cycle the load sits in MEM/WB and forwarding rule 2 supplies its value.
- flush_i and load_use in the same cycle: the slot becomes EMPTY and stall_o=0.

## Structure
- core_pkg holds:
  - ctrl_t packed struct: alu_op, alu_src_imm, uses_rs1, uses_rs2, mem_read, mem_write, write_back, branch, jump;
  - XLEN;
  - REG_ZERO constant.
- Sub-module operand_forward, instantiated twice (rs1, rs2). It implements the combinational priority mux, including the x0 rule.

## Test plan
- ALU dependency: EX/MEM writes x5=0x10 while the slot holds rs1=x5 with a stale captured 0 → ex_op_a_o=0x10. With MEM/WB also writing x5=0x20, the output is still 0x10.
- Load-use: slot holds a load to x7, ID presents rs2=x7 → stall_o=1 for one cycle, next cycle ex_valid_o=0. The following cycle the dependent is captured, and with wb_data_i=0xCAFE, ex_op_b_o=0xCAFE.
- x0: mem_rd_i=0, mem_write_back_i=1, mem_result_i=0xDEAD, slot rs1=0 → ex_op_a_o=0.
- Hold: ex_ready_i=0 for 3 cycles, and WB writes the held rs1=0x55 in cycle 2 → stall_o=1 throughout, the slot is unchanged, and ex_op_a_o=0x55 from cycle 2 through release.
- Flush: flush_i together with load_use and !ex_ready_i → stall_o=0, ex_valid_o=0 next cycle.
- Reset mid-hold: reset_i=0 for one edge → all ex_* outputs are 0 and stall_o=0 after that edge.
